// File: rtl/priority_router_pkg.sv
// priority_router_pkg: shared widths, candidate record and tree sizing helper
package priority_router_pkg;

    localparam int unsigned DATA_WIDTH    = 32;
    localparam int unsigned VERSION_WIDTH = 4;
    localparam int unsigned VERSION_NUM   = 4;

    localparam int unsigned INDEX_WIDTH = (VERSION_NUM > 1) ? $clog2(VERSION_NUM) : 1;

    // Candidate record at the default widths; the top builds its own copy at its actual widths
    typedef struct packed {
        logic                     valid;
        logic [VERSION_WIDTH-1:0] version;
        logic [INDEX_WIDTH-1:0]   index;
        logic [DATA_WIDTH-1:0]    data;
    } cand_t;

    // Number of tree levels needed to reduce n leaves to one root
    function automatic int unsigned tree_levels(input int unsigned n);
        return (n > 1) ? $clog2(n) : 0;
    endfunction

endpackage

// File: rtl/priority_router_node.sv
// priority_router_node: combinational two-input tournament node
module priority_router_node
    import priority_router_pkg::*;
#(
    parameter type node_cand_t = cand_t
) (
    input  node_cand_t a,
    input  node_cand_t b,
    output node_cand_t y
);

    logic a_wins;

    // a wins when it is the only valid one, is newer, or ties with a lower index
    always_comb begin
        a_wins = a.valid && (!b.valid || (a.version > b.version) ||
                 ((a.version == b.version) && (a.index <= b.index)));
        y      = a_wins ? a : b;
    end

endmodule

// File: rtl/priority_router.sv
// priority_router: picks the newest version not exceeding readVersion, registered output
module priority_router
    import priority_router_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = priority_router_pkg::DATA_WIDTH,
    parameter int unsigned VERSION_WIDTH = priority_router_pkg::VERSION_WIDTH,
    parameter int unsigned VERSION_NUM   = priority_router_pkg::VERSION_NUM
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [VERSION_WIDTH*VERSION_NUM-1:0] versions,
    input  logic [DATA_WIDTH*VERSION_NUM-1:0]    dataInputs,
    input  logic [VERSION_WIDTH-1:0]         readVersion,
    output logic [DATA_WIDTH-1:0]            dataOut,
    output logic                             hit
);

    localparam int unsigned LEVELS = tree_levels(VERSION_NUM);
    localparam int unsigned LEAVES = 1 << LEVELS;
    localparam int unsigned IDX_W  = (LEAVES > 1) ? LEVELS : 1;

    typedef struct packed {
        logic                     valid;
        logic [VERSION_WIDTH-1:0] version;
        logic [IDX_W-1:0]         index;
        logic [DATA_WIDTH-1:0]    data;
    } rcand_t;

    // Heap-ordered tree: node k has children 2k+1 and 2k+2, leaves start at LEAVES-1
    rcand_t tree [2*LEAVES-1];

    logic [DATA_WIDTH-1:0] dataOut_d, dataOut_q;
    logic                  hit_d, hit_q;

    genvar i;
    generate
        for (i = 0; i < LEAVES; i++) begin : g_leaf
            if (i < VERSION_NUM) begin : g_real
                assign tree[LEAVES-1+i] = '{
                    valid:   versions[i*VERSION_WIDTH +: VERSION_WIDTH] <= readVersion,
                    version: versions[i*VERSION_WIDTH +: VERSION_WIDTH],
                    index:   IDX_W'(i),
                    data:    dataInputs[i*DATA_WIDTH +: DATA_WIDTH]
                };
            end else begin : g_pad
                assign tree[LEAVES-1+i] = '0;
            end
        end
        for (i = 0; i < LEAVES - 1; i++) begin : g_node
            priority_router_node #(.node_cand_t(rcand_t)) u_node (
                .a(tree[2*i+1]),
                .b(tree[2*i+2]),
                .y(tree[i])
            );
        end
    endgenerate

    // Root result; a miss forces zero data regardless of what the tree carried
    always_comb begin
        hit_d     = tree[0].valid;
        dataOut_d = tree[0].valid ? tree[0].data : '0;
    end

    // One-cycle output stage with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            dataOut_q <= '0;
            hit_q     <= 1'b0;
        end else begin
            dataOut_q <= dataOut_d;
            hit_q     <= hit_d;
        end
    end

    assign dataOut = dataOut_q;
    assign hit     = hit_q;

endmodule

// File: tb/tb_priority_router.sv
// tb_priority_router: directed and random checks of the version-selecting router
module tb_priority_router;

    localparam int DW = 32;
    localparam int VW = 4;
    localparam int VN = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [VW*VN-1:0]    versions;
    logic [DW*VN-1:0]    dataInputs;
    logic [VW-1:0]       readVersion;
    logic [DW-1:0]       dataOut;
    logic                hit;

    int total = 0;
    int bad   = 0;

    priority_router #(.DATA_WIDTH(DW), .VERSION_WIDTH(VW), .VERSION_NUM(VN)) dut (
        .clk(clk),
        .rst(rst),
        .versions(versions),
        .dataInputs(dataInputs),
        .readVersion(readVersion),
        .dataOut(dataOut),
        .hit(hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one request, let one edge pass, then compare the registered result
    task automatic step(input string tag, input logic r, input logic [15:0] v, input logic [3:0] rv,
                        input logic [31:0] exp_d, input logic exp_h);
        @(negedge clk);
        rst         = r;
        versions    = v;
        readVersion = rv;
        @(posedge clk);
        #1;
        check({tag, ".data"}, 64'(dataOut), 64'(exp_d));
        check({tag, ".hit"},  64'(hit),     64'(exp_h));
    endtask

    // Independent reference: linear scan, strict greater keeps the lowest index on ties
    function automatic logic [32:0] model(input logic [15:0] v, input logic [127:0] d, input logic [3:0] rv);
        int best = -1;
        logic [3:0] bv = '0;
        for (int k = 0; k < VN; k++) begin
            if (v[k*4 +: 4] <= rv && (best < 0 || v[k*4 +: 4] > bv)) begin
                best = k;
                bv   = v[k*4 +: 4];
            end
        end
        return (best < 0) ? 33'd0 : {1'b1, d[best*32 +: 32]};
    endfunction

    initial begin
        logic [32:0] exp;
        rst         = 1'b1;
        versions    = 16'h9572;
        readVersion = 4'd6;
        dataInputs  = 128'h000000D3_000000C2_000000B1_000000A0;

        step("rst0", 1'b1, 16'h9572, 4'd6, 32'h0, 1'b0);
        step("rst1", 1'b1, 16'hFFFF, 4'd15, 32'h0, 1'b0);
        step("first", 1'b0, 16'h9572, 4'd6, 32'hC2, 1'b1);
        step("rv9", 1'b0, 16'h9572, 4'd9, 32'hD3, 1'b1);
        step("exact5", 1'b0, 16'h9572, 4'd5, 32'hC2, 1'b1);
        step("rv1miss", 1'b0, 16'h9572, 4'd1, 32'h0, 1'b0);
        step("tie", 1'b0, 16'h3133, 4'd4, 32'hA0, 1'b1);
        step("miss", 1'b0, 16'hFA98, 4'd7, 32'h0, 1'b0);
        step("rv0", 1'b0, 16'h6004, 4'd0, 32'hB1, 1'b1);
        step("rv15", 1'b0, 16'h1F2F, 4'd15, 32'hA0, 1'b1);
        step("midrst", 1'b1, 16'h1F2F, 4'd15, 32'h0, 1'b0);
        step("after", 1'b0, 16'h1F2F, 4'd15, 32'hA0, 1'b1);

        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            rst         = (n == 500);
            versions    = 16'($urandom);
            readVersion = 4'($urandom);
            dataInputs  = {$urandom, $urandom, $urandom, $urandom};
            exp         = rst ? 33'd0 : model(versions, dataInputs, readVersion);
            @(posedge clk);
            #1;
            check($sformatf("rnd%0d", n), {31'd0, hit, dataOut}, {31'd0, exp});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
